// File: rtl/bus_echo_checker_if.sv
// Control and status handshake between the echo checker and the test controller.
interface bus_echo_checker_if #(
    parameter int ERR_W = 8
) ();
    logic             Start;
    logic             Busy;
    logic             Locked;
    logic             Done;
    logic             Fail;
    logic [ERR_W-1:0] ErrCnt;

    modport master (output Start, input Busy, Locked, Done, Fail, ErrCnt);
    modport slave  (input Start, output Busy, Locked, Done, Fail, ErrCnt);
endinterface

// File: rtl/bus_echo_checker.sv
// Far-side link partner for the bidirectional echo stage: alternates drive/listen
// slots on Data, hunts for the echo phase, then counts echo errors over a fixed run.
module bus_echo_checker #(
    parameter int DATA_W    = 4,
    parameter int RUN_LEN   = 64,
    parameter int LOCK_GOOD = 4,
    parameter int HUNT_MAX  = 32,
    parameter int ERR_W     = 8
) (
    input  logic              CLK,
    input  logic              RSTn,
    inout  wire  [DATA_W-1:0] Data,
    bus_echo_checker_if.slave ctl
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HUNT = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int CNT_MAX = (RUN_LEN > HUNT_MAX) ? RUN_LEN : HUNT_MAX;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int GOOD_W  = $clog2(LOCK_GOOD + 1);

    logic [1:0]        state_q;
    logic              slot_q;     // 1 = drive slot, 0 = listen slot
    logic              hold_q;     // extra listen cycle after a hunt mismatch
    logic              drv_q;
    logic [DATA_W-1:0] pat_q;
    logic [CNT_W-1:0]  cmp_cnt_q;
    logic [GOOD_W-1:0] good_q;
    logic              locked_q;
    logic              fail_q;
    logic [ERR_W-1:0]  err_q;
    logic              match;
    logic              last_hunt;
    logic              last_run;

    function automatic logic [DATA_W-1:0] pat_adv(input logic [DATA_W-1:0] p);
        logic [DATA_W-1:0] n;
        n = p + 1'b1;
        if (n == '0) n = {{(DATA_W-1){1'b0}}, 1'b1};
        return n;
    endfunction

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == {ERR_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Pattern is never zero, so a released bus (Z, or 0 in two-state models) always mismatches.
    assign match     = (Data === pat_q);
    assign last_hunt = (cmp_cnt_q == CNT_W'(HUNT_MAX - 1));
    assign last_run  = (cmp_cnt_q == CNT_W'(RUN_LEN - 1));

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q   <= ST_IDLE;
            slot_q    <= 1'b1;
            hold_q    <= 1'b0;
            drv_q     <= 1'b0;
            pat_q     <= {{(DATA_W-1){1'b0}}, 1'b1};
            cmp_cnt_q <= '0;
            good_q    <= '0;
            locked_q  <= 1'b0;
            fail_q    <= 1'b0;
            err_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ctl.Start) begin
                        state_q   <= ST_HUNT;
                        slot_q    <= 1'b1;
                        hold_q    <= 1'b0;
                        drv_q     <= 1'b1;
                        pat_q     <= {{(DATA_W-1){1'b0}}, 1'b1};
                        cmp_cnt_q <= '0;
                        good_q    <= '0;
                        locked_q  <= 1'b0;
                        fail_q    <= 1'b0;
                        err_q     <= '0;
                    end
                end
                ST_HUNT, ST_RUN: begin
                    if (slot_q) begin
                        slot_q <= 1'b0;
                        drv_q  <= 1'b0;
                    end else if (hold_q) begin
                        hold_q <= 1'b0;
                        slot_q <= 1'b1;
                        drv_q  <= 1'b1;
                    end else begin
                        // End of a listen slot: compare against the pattern just sent.
                        pat_q     <= pat_adv(pat_q);
                        cmp_cnt_q <= cmp_cnt_q + CNT_W'(1);
                        if (state_q == ST_HUNT) begin
                            if (match) begin
                                slot_q <= 1'b1;
                                drv_q  <= 1'b1;
                                if (good_q == GOOD_W'(LOCK_GOOD - 1)) begin
                                    good_q    <= '0;
                                    locked_q  <= 1'b1;
                                    cmp_cnt_q <= '0;
                                    state_q   <= ST_RUN;
                                end else begin
                                    good_q <= good_q + GOOD_W'(1);
                                    if (last_hunt) begin
                                        fail_q  <= 1'b1;
                                        drv_q   <= 1'b0;
                                        state_q <= ST_DONE;
                                    end
                                end
                            end else begin
                                good_q <= '0;
                                hold_q <= 1'b1;
                                if (last_hunt) begin
                                    fail_q  <= 1'b1;
                                    state_q <= ST_DONE;
                                end
                            end
                        end else begin
                            slot_q <= 1'b1;
                            drv_q  <= 1'b1;
                            if (!match) err_q <= sat_inc(err_q);
                            if (last_run) begin
                                drv_q   <= 1'b0;
                                state_q <= ST_DONE;
                            end
                        end
                    end
                end
                default: begin
                    drv_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign Data       = drv_q ? pat_q : 'z;
    assign ctl.Busy   = (state_q == ST_HUNT) || (state_q == ST_RUN);
    assign ctl.Done   = (state_q == ST_DONE);
    assign ctl.Locked = locked_q;
    assign ctl.Fail   = fail_q;
    assign ctl.ErrCnt = err_q;
endmodule

// File: tb/tb_bus_echo_checker.sv
// Directed bench for bus_echo_checker: phase-aligned and offset echo partners,
// floating bus, injected errors, counter saturation and mid-run reset.
module tb_bus_echo_checker;
    logic      CLK;
    logic      RSTn;
    wire [3:0] Data0;
    wire [3:0] Data1;

    bus_echo_checker_if #(.ERR_W(8)) if0 ();
    bus_echo_checker_if #(.ERR_W(2)) if1 ();

    bus_echo_checker #(.DATA_W(4), .RUN_LEN(64), .LOCK_GOOD(4), .HUNT_MAX(32), .ERR_W(8)) u0 (
        .CLK(CLK), .RSTn(RSTn), .Data(Data0), .ctl(if0));
    bus_echo_checker #(.DATA_W(4), .RUN_LEN(64), .LOCK_GOOD(4), .HUNT_MAX(32), .ERR_W(2)) u1 (
        .CLK(CLK), .RSTn(RSTn), .Data(Data1), .ctl(if1));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int nchk  = 0;
    int npass = 0;
    int nfail = 0;

    // Far-side echo partner: captures on phase 0, echoes the capture on phase 1.
    logic       e0_on = 1'b0, e0_ph = 1'b0, e0_ph0 = 1'b1, e0_v = 1'b0;
    logic [3:0] e0_cap = 4'h0;
    int         e0_n = 0, e0_fa = -1, e0_fb = -1;
    logic       e1_on = 1'b0, e1_ph = 1'b0, e1_v = 1'b0;
    logic [3:0] e1_cap = 4'h0;
    int         e1_n = 0;
    logic       e0_flip, e1_flip;

    function automatic logic seen(input logic [3:0] d);
        return (^d !== 1'bx) && (d != 4'h0);
    endfunction

    function automatic logic released(input logic [3:0] d);
        return (d === 4'bzzzz) || (d === 4'b0000);
    endfunction

    always @(posedge CLK) begin
        if (!e0_on) begin
            e0_ph <= e0_ph0; e0_v <= 1'b0; e0_n <= 0;
        end else begin
            e0_ph <= ~e0_ph;
            if (!e0_ph) begin
                e0_cap <= Data0; e0_v <= seen(Data0);
                if (seen(Data0)) e0_n <= e0_n + 1;
            end
        end
    end

    always @(posedge CLK) begin
        if (!e1_on) begin
            e1_ph <= 1'b1; e1_v <= 1'b0; e1_n <= 0;
        end else begin
            e1_ph <= ~e1_ph;
            if (!e1_ph) begin
                e1_cap <= Data1; e1_v <= seen(Data1);
                if (seen(Data1)) e1_n <= e1_n + 1;
            end
        end
    end

    assign e0_flip = (e0_n == e0_fa) || (e0_n == e0_fb);
    assign e1_flip = (e1_n > 4);
    assign Data0 = (e0_on && e0_ph && e0_v) ? (e0_cap ^ {3'b000, e0_flip}) : 4'bzzzz;
    assign Data1 = (e1_on && e1_ph && e1_v) ? (e1_cap ^ {3'b000, e1_flip}) : 4'bzzzz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0: return if0.Locked;
            1: return if0.Done;
            2: return if1.Locked;
            default: return if1.Done;
        endcase
    endfunction

    task automatic wait_for(input int sel, input int limit, output int n);
        n = 0;
        while (!sig(sel) && n < limit) begin
            @(negedge CLK);
            n++;
        end
    endtask

    task automatic start0(input logic echo);
        @(negedge CLK);
        e0_on = echo;
        if0.Start = 1'b1;
        @(negedge CLK);
        if0.Start = 1'b0;
    endtask

    task automatic finish0;
        e0_on = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        int n, idx, bad_rel, bad_pat;
        logic [3:0] ep;
        if0.Start = 1'b0;
        if1.Start = 1'b0;
        RSTn = 1'b1;
        #2 RSTn = 1'b0;
        @(negedge CLK);
        chk("rst_busy", if0.Busy, 0);
        chk("rst_locked", if0.Locked, 0);
        chk("rst_done", if0.Done, 0);
        chk("rst_fail", if0.Fail, 0);
        chk("rst_errcnt", if0.ErrCnt, 0);
        chk("rst_bus_released", released(Data0), 1);
        chk("rst_errcnt_u1", if1.ErrCnt, 0);
        @(negedge CLK);
        RSTn = 1'b1;
        repeat (2) @(negedge CLK);

        // Aligned echo
        e0_ph0 = 1'b1;
        start0(1'b1);
        chk("ideal_busy", if0.Busy, 1);
        chk("ideal_first_drive", Data0, 4'h1);
        wait_for(0, 40, n);
        chk("ideal_lock_cycles", n, 8);
        wait_for(1, 300, n);
        chk("ideal_done_cycles", n, 128);
        chk("ideal_busy_at_done", if0.Busy, 0);
        chk("ideal_errcnt", if0.ErrCnt, 0);
        chk("ideal_fail", if0.Fail, 0);
        chk("ideal_locked_hold", if0.Locked, 1);
        @(negedge CLK);
        chk("ideal_done_one_cycle", if0.Done, 0);
        finish0();

        // Echo one cycle out of phase: one swap, lock after 5 compares
        e0_ph0 = 1'b0;
        start0(1'b1);
        wait_for(0, 40, n);
        chk("offset_lock_cycles", n, 11);
        wait_for(1, 300, n);
        chk("offset_done_cycles", n, 128);
        chk("offset_errcnt", if0.ErrCnt, 0);
        chk("offset_fail", if0.Fail, 0);
        finish0();

        // No echo: hunt times out after 32 compares, 3 cycles each
        start0(1'b0);
        idx = 0; bad_rel = 0; bad_pat = 0; ep = 4'h1;
        while (!if0.Done && idx < 400) begin
            if (idx % 3 == 0) begin
                if (Data0 !== ep) bad_pat++;
                ep = (ep == 4'hF) ? 4'h1 : ep + 4'h1;
            end else if (!released(Data0)) begin
                bad_rel++;
            end
            @(negedge CLK);
            idx++;
        end
        chk("float_done_cycles", idx, 95);
        chk("float_listen_released", bad_rel, 0);
        chk("float_drive_pattern", bad_pat, 0);
        chk("float_fail", if0.Fail, 1);
        chk("float_locked", if0.Locked, 0);
        chk("float_errcnt", if0.ErrCnt, 0);
        finish0();
        chk("float_fail_holds", if0.Fail, 1);

        // Bit 0 flipped on RUN compares 10 and 40; a stray Start mid-run is ignored
        e0_ph0 = 1'b1; e0_fa = 14; e0_fb = 44;
        start0(1'b1);
        chk("flip_fail_cleared", if0.Fail, 0);
        wait_for(0, 40, n);
        chk("flip_lock_cycles", n, 8);
        repeat (5) @(negedge CLK);
        if0.Start = 1'b1;
        @(negedge CLK);
        if0.Start = 1'b0;
        repeat (14) @(negedge CLK);
        chk("stray_start_busy", if0.Busy, 1);
        chk("stray_start_locked", if0.Locked, 1);
        wait_for(1, 300, n);
        chk("flip_done_cycles", n, 108);
        chk("flip_errcnt", if0.ErrCnt, 2);
        chk("flip_fail", if0.Fail, 0);
        e0_fa = -1; e0_fb = -1;
        finish0();

        // Two-bit error counter with every RUN echo wrong
        @(negedge CLK);
        e1_on = 1'b1;
        if1.Start = 1'b1;
        @(negedge CLK);
        if1.Start = 1'b0;
        wait_for(2, 40, n);
        chk("sat_lock_cycles", n, 8);
        repeat (2) @(negedge CLK);
        chk("sat_first_error", if1.ErrCnt, 1);
        wait_for(3, 300, n);
        chk("sat_done_cycles", n, 126);
        chk("sat_errcnt", if1.ErrCnt, 3);
        chk("sat_fail", if1.Fail, 0);
        e1_on = 1'b0;
        repeat (2) @(negedge CLK);

        // Asynchronous reset in the middle of RUN, during a drive slot
        e0_ph0 = 1'b1;
        start0(1'b1);
        wait_for(0, 40, n);
        repeat (20) @(negedge CLK);
        chk("prerst_drive_pat", Data0, 4'hF);
        #1 RSTn = 1'b0;
        #1;
        chk("midrst_busy", if0.Busy, 0);
        chk("midrst_locked", if0.Locked, 0);
        chk("midrst_done", if0.Done, 0);
        chk("midrst_fail", if0.Fail, 0);
        chk("midrst_errcnt", if0.ErrCnt, 0);
        chk("midrst_bus_released", released(Data0), 1);
        @(negedge CLK);
        e0_on = 1'b0;
        RSTn = 1'b1;
        repeat (3) @(negedge CLK);
        chk("postrst_idle", if0.Busy, 0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule

// File: doc/bus_echo_checker.md
# bus_echo_checker

Link partner for the 4-bit bidirectional echo stage. It sits on the far side of the shared `Data` bus and runs from the forwarded clock. It alternates driving a test pattern and releasing the bus, then samples the value echoed back and compares it with what it sent. It finds the correct slot phase on its own, then counts echo errors over a fixed-length run and reports pass/fail to the test controller.

## Interface
- `DATA_W`, 4, bus width
- `RUN_LEN`, 64, compares per run after lock (≥1)
- `LOCK_GOOD`, 4, consecutive matching compares needed to declare lock (≥1)
- `HUNT_MAX`, 32, compares allowed in hunt before giving up
- `ERR_W`, 8, error counter width

- `CLK`  in  1  clock (forwarded ext_clk)
- `RSTn`  in  1  reset, asynchronous, active-low
- `Data`  inout  DATA_W  shared echo bus; driven only in drive slots, else `'z`
- `Start`  in  1  one-cycle pulse, starts a run; honoured only in IDLE
- `Busy`  out  1  high in HUNT/RUN
- `Locked`  out  1  slot phase found
- `Done`  out  1  one-cycle pulse at run end
- `Fail`  out  1  hunt timed out; valid from `Done` until next `Start`
- `ErrCnt`  out  ERR_W  mismatches during RUN, saturating

## Operation
- FSM: IDLE → HUNT → RUN → DONE → IDLE.
- Reset values: all outputs 0, bus released, FSM IDLE, pattern = 1, slot = drive.
- Slot flop `slot` toggles every cycle in HUNT/RUN. Drive slot: `Data` = `pat`. Listen slot: bus released.
- Compare: at the clock edge that ends each listen slot, `Data` is compared with the `pat` value driven in the immediately preceding drive slot. Any X/Z bit counts as a mismatch.
- `pat` advances (+1 mod 2^DATA_W, skipping 0) after each compare.
- IDLE + `Start`: clear `ErrCnt`, `Locked` and `Fail`; set slot = drive and pat = 1; go to HUNT.
- HUNT:
  - Match: increment the good counter. Reaching LOCK_GOOD sets `Locked` and enters RUN.
  - Mismatch: clear the good counter and hold `slot` for one extra cycle, which swaps the drive/listen phase.
  - HUNT_MAX compares without lock: set `Fail`, go to DONE.
- RUN:
  - Exactly RUN_LEN compares.
  - Each mismatch increments `ErrCnt`, which saturates at 2^ERR_W−1.
  - `Locked` stays high in RUN; it does not drop on errors.
- DONE: assert `Done` for one cycle, release the bus, return to IDLE. `Locked`, `Fail` and `ErrCnt` hold.
- `Start` outside IDLE is ignored.
- Asynchronous reset mid-run returns every register to its reset value immediately. The bus is released in the same instant.

## Timing
- Bus drive enable and drive value come straight from flops; no combinational path from `Data` to `Data`.
- Drive slot and listen slot are each one CLK cycle. The compare period is 2 cycles.
- `Start` at edge n puts the FSM in HUNT at n+1 and drives `Data` = 1 during cycle n+1.
- Best-case lock: LOCK_GOOD compares, 2·LOCK_GOOD cycles after HUNT entry.
- A phase swap costs one extra cycle.
- RUN lasts 2·RUN_LEN cycles. `Done` is high the cycle after the final compare.
- Hunt timeout: `Done` ≤ 2·HUNT_MAX + HUNT_MAX cycles after HUNT entry.
- `Busy` falls in the same cycle `Done` rises.

## Test plan
- Ideal echo model, correct phase at HUNT entry, `Start` → `Locked` after 4 compares, `Done` after 64 more, `ErrCnt`=0, `Fail`=0.
- Echo model offset by one cycle → exactly one phase swap in HUNT, then lock; `ErrCnt`=0.
- Bus left floating (no echo) → `Fail`=1, `Locked`=0, `Done` after 32 compares. `Data` is never driven during listen slots.
- Echo model flips bit 0 on RUN compares 10 and 40 → `ErrCnt`=2, `Fail`=0.
- ERR_W=2 with an echo that is always wrong after lock → `ErrCnt` saturates at 3 and does not wrap.
- `RSTn` low mid-RUN → all outputs 0 and bus `'z` immediately. A `Start` pulse while `Busy` does not restart the run.
